csr_host_sequencer: RTL

- Avalon-MM initiator that drives the checker CSR responder over a single system clock.
- Accepts one test command (parameter set), writes the parameter CSRs, then writes the start bit.
- Polls the read-to-clear test-finish CSR, then reads back the result CSRs.
- Presents results to a downstream consumer through a valid/ready handshake. Used as the on-chip host for self-test and for bench stimulus.

---
 rtl/csr_host_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/csr_host_sequencer.sv
// Avalon-MM host: writes a test parameter set to the checker CSRs, starts the test,
// polls the read-to-clear finish flag, then reads the results back and hands them downstream.
module csr_host_sequencer #(
  parameter int PARAM_FIRST_ADDR  = 1,
  parameter int PARAM_CNT         = 5,
  parameter int START_ADDR        = 0,
  parameter int FINISH_ADDR       = 6,
  parameter int RESULT_FIRST_ADDR = 7,
  parameter int RESULT_CNT        = 4,
  parameter int POLL_INTERVAL     = 16,
  parameter int POLL_MAX          = 1024
) (
  input  logic                       clk_sys_i,
  input  logic                       rst_sys_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [PARAM_CNT-1:0][31:0] cmd_param_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [RESULT_CNT-1:0][31:0] result_o,
  output logic                       timeout_o,
  output logic                       busy_o,
  output logic                       read_o,
  output logic                       write_o,
  output logic [3:0]                 address_o,
  output logic [31:0]                writedata_o,
  input  logic                       readdatavalid_i,
  input  logic [31:0]                readdata_i
);

  localparam int PIW = (PARAM_CNT > 1) ? $clog2(PARAM_CNT) : 1;
  localparam int RIW = (RESULT_CNT > 1) ? $clog2(RESULT_CNT) : 1;
  localparam int PCW = $clog2(POLL_MAX + 1);
  localparam int WW  = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

  localparam logic [3:0] PF_ADDR = 4'(PARAM_FIRST_ADDR);
  localparam logic [3:0] ST_ADDR = 4'(START_ADDR);
  localparam logic [3:0] FN_ADDR = 4'(FINISH_ADDR);
  localparam logic [3:0] RF_ADDR = 4'(RESULT_FIRST_ADDR);

  typedef enum logic [3:0] {
    IDLE, WR_PARAM, WR_START, POLL_WAIT, POLL_RD, POLL_RSP, RES_RD, RES_RSP, DONE
  } state_t;

  state_t                     state;
  logic [PARAM_CNT-1:0][31:0] param_q;
  logic [PIW-1:0]             p_idx;
  logic [RIW-1:0]             r_idx;
  logic [PCW-1:0]             poll_cnt;
  logic [WW-1:0]              wait_cnt;
  logic [PIW-1:0]             p_idx_nxt;
  logic [RIW-1:0]             r_idx_nxt;

  assign p_idx_nxt = p_idx + PIW'(1);
  assign r_idx_nxt = r_idx + RIW'(1);

  // Strobes and addresses are registered on entry to the state that owns them,
  // so each bus cycle lines up exactly with its FSM state.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state          <= IDLE;
      param_q        <= '0;
      p_idx          <= '0;
      r_idx          <= '0;
      poll_cnt       <= '0;
      wait_cnt       <= '0;
      cmd_ready_o    <= 1'b0;
      result_valid_o <= 1'b0;
      result_o       <= '0;
      timeout_o      <= 1'b0;
      busy_o         <= 1'b0;
      read_o         <= 1'b0;
      write_o        <= 1'b0;
      address_o      <= '0;
      writedata_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o) begin
            param_q     <= cmd_param_i;
            result_o    <= '0;
            poll_cnt    <= '0;
            p_idx       <= '0;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            write_o     <= 1'b1;
            address_o   <= PF_ADDR;
            writedata_o <= cmd_param_i[0];
            state       <= WR_PARAM;
          end
        end
        WR_PARAM: begin
          if (p_idx == PIW'(PARAM_CNT - 1)) begin
            address_o   <= ST_ADDR;
            writedata_o <= 32'h1;
            state       <= WR_START;
          end else begin
            p_idx       <= p_idx_nxt;
            address_o   <= PF_ADDR + 4'(p_idx_nxt);
            writedata_o <= param_q[p_idx_nxt];
          end
        end
        WR_START: begin
          write_o  <= 1'b0;
          wait_cnt <= WW'(POLL_INTERVAL - 1);
          state    <= POLL_WAIT;
        end
        POLL_WAIT: begin
          if (wait_cnt == '0) begin
            read_o    <= 1'b1;
            address_o <= FN_ADDR;
            state     <= POLL_RD;
          end else begin
            wait_cnt <= wait_cnt - WW'(1);
          end
        end
        POLL_RD: begin
          read_o <= 1'b0;
          if (poll_cnt != PCW'(POLL_MAX)) poll_cnt <= poll_cnt + PCW'(1);
          state <= POLL_RSP;
        end
        POLL_RSP: begin
          if (readdatavalid_i) begin
            if (readdata_i[0]) begin
              r_idx     <= '0;
              read_o    <= 1'b1;
              address_o <= RF_ADDR;
              state     <= RES_RD;
            end else if (poll_cnt == PCW'(POLL_MAX)) begin
              timeout_o      <= 1'b1;
              result_valid_o <= 1'b1;
              state          <= DONE;
            end else begin
              wait_cnt <= WW'(POLL_INTERVAL - 1);
              state    <= POLL_WAIT;
            end
          end
        end
        RES_RD: begin
          read_o <= 1'b0;
          state  <= RES_RSP;
        end
        RES_RSP: begin
          if (readdatavalid_i) begin
            result_o[r_idx] <= readdata_i;
            if (r_idx == RIW'(RESULT_CNT - 1)) begin
              result_valid_o <= 1'b1;
              state          <= DONE;
            end else begin
              r_idx     <= r_idx_nxt;
              read_o    <= 1'b1;
              address_o <= RF_ADDR + 4'(r_idx_nxt);
              state     <= RES_RD;
            end
          end
        end
        DONE: begin
          if (result_ready_i) begin
            result_valid_o <= 1'b0;
            timeout_o      <= 1'b0;
            busy_o         <= 1'b0;
            cmd_ready_o    <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
